// File: rtl/seq_pkg.sv
// Shared encodings for the BBCCC match controller: controller states,
// one-hot detector states and the serial symbol values.
package seq_pkg;

    typedef enum logic {
        CtlIdle = 1'b0,
        CtlRun  = 1'b1
    } ctl_state_e;

    typedef enum logic [4:0] {
        DetReset = 5'b00001,
        DetB     = 5'b00010,
        DetBb    = 5'b00100,
        DetBbc   = 5'b01000,
        DetBbcc  = 5'b10000
    } det_state_e;

    localparam logic SymB = 1'b0;
    localparam logic SymC = 1'b1;

endpackage

// File: rtl/seq_bbccc_det.sv
// Non-overlapping Mealy detector for the serial sequence B B C C C.
// hit is combinational in the cycle the final C is presented with en=1.
module seq_bbccc_det
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic hit
);

    det_state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DetReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (clr) begin
            state_d = DetReset;
        end else if (en) begin
            unique case (state_q)
                DetReset: state_d = (din == SymB) ? DetB   : DetReset;
                DetB:     state_d = (din == SymB) ? DetBb  : DetReset;
                DetBb:    state_d = (din == SymB) ? DetBb  : DetBbc;
                DetBbc:   state_d = (din == SymB) ? DetB   : DetBbcc;
                DetBbcc: begin
                    // Both symbols restart the search; a C completes the match.
                    state_d = DetReset;
                    hit     = (din == SymC);
                end
                default:  state_d = DetReset;
            endcase
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller: counts BBCCC matches inside a cycle window and reports
// completion (done) or window expiry (timeout) as one-cycle pulses.
module seq_match_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    input  logic [CNT_W-1:0] target,
    input  logic [WIN_W-1:0] window,
    output logic             busy,
    output logic             pattern,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);

    ctl_state_e       state_q, state_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] cyc_q, cyc_d;
    logic             pattern_q, pattern_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic det_clr, det_en, hit;
    logic complete, expire;

    assign det_en = (state_q == CtlRun) && din_valid;

    seq_bbccc_det u_det (
        .clk (clk),
        .rst (rst),
        .clr (det_clr),
        .en  (det_en),
        .din (din),
        .hit (hit)
    );

    // In RUN match_cnt < target always holds, so +1 cannot overshoot.
    assign complete = hit && ((cnt_q + CntOne) == tgt_q);
    assign expire   = (cyc_q == (win_q - WinOne));

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        pattern_d = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        det_clr   = 1'b0;
        unique case (state_q)
            CtlIdle: begin
                if (start) begin
                    if (target == '0) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else if (window == '0) begin
                        timeout_d = 1'b1;
                    end else begin
                        tgt_d   = target;
                        win_d   = window;
                        cnt_d   = '0;
                        cyc_d   = '0;
                        det_clr = 1'b1;
                        state_d = CtlRun;
                    end
                end
            end
            CtlRun: begin
                cyc_d = cyc_q + WinOne;
                if (hit) begin
                    cnt_d     = cnt_q + CntOne;
                    pattern_d = 1'b1;
                end
                // abort beats completion, completion beats expiry.
                if (abort) begin
                    state_d = CtlIdle;
                end else if (complete) begin
                    done_d  = 1'b1;
                    state_d = CtlIdle;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = CtlIdle;
                end
            end
            default: state_d = CtlIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CtlIdle;
            tgt_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            cyc_q     <= '0;
            pattern_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            pattern_q <= pattern_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy      = (state_q == CtlRun);
    assign pattern   = pattern_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: directed runs push expected output
// pulses (with their cycle number); a negedge monitor pops and compares.
module tb_seq_match_ctrl;

    localparam int CW = 8;
    localparam int WW = 16;
    localparam logic B = 1'b0;
    localparam logic C = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic [CW-1:0] target = '0;
    logic [WW-1:0] window = '0;
    logic          busy, pattern, done, timeout;
    logic [CW-1:0] match_cnt;

    typedef struct {
        logic          pat;
        logic          dn;
        logic          to;
        logic          bsy;
        logic [CW-1:0] cnt;
        int            at;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    seq_match_ctrl #(
        .CNT_W (CW),
        .WIN_W (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .din       (din),
        .din_valid (din_valid),
        .target    (target),
        .window    (window),
        .busy      (busy),
        .pattern   (pattern),
        .match_cnt (match_cnt),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(input logic p, input logic d, input logic t, input logic b,
                          input int cnt, input int at);
        ev_t e;
        e.pat = p; e.dn = d; e.to = t; e.bsy = b; e.cnt = CW'(cnt); e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic a, input logic d, input logic v);
        start = s; abort = a; din = d; din_valid = v;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; din_valid = 1'b0;
    endtask

    task automatic sym(input logic d);
        step(1'b0, 1'b0, d, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input int t, input int w, output int s);
        target = CW'(t);
        window = WW'(w);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst) begin
            if (done && timeout) begin
                checks++;
                errors++;
                $display("FAIL done_and_timeout: both high at cycle %0d", cyc);
            end
            if (pattern || done || timeout) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got pat=%0b done=%0b to=%0b cnt=%0d at %0d, expected none",
                             pattern, done, timeout, match_cnt, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (pattern !== e.pat || done !== e.dn || timeout !== e.to ||
                        busy !== e.bsy || match_cnt !== e.cnt || cyc != e.at) begin
                        errors++;
                        $display("FAIL pulse: got pat=%0b done=%0b to=%0b busy=%0b cnt=%0d at %0d, expected pat=%0b done=%0b to=%0b busy=%0b cnt=%0d at %0d",
                                 pattern, done, timeout, busy, match_cnt, cyc,
                                 e.pat, e.dn, e.to, e.bsy, e.cnt, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pattern", pattern, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_match_cnt", match_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single match, start on the first edge after reset.
        go(1, 20, s);
        chk("t1_busy_run", busy, 1);
        sym(B); sym(B); sym(C); sym(C);
        exp_ev(1, 1, 0, 0, 1, s + 5);
        sym(C);
        idle(1);
        chk("t1_busy_end", busy, 0);
        chk("t1_cnt", match_cnt, 1);

        // Two back-to-back matches.
        go(2, 30, s);
        exp_ev(1, 0, 0, 1, 1, s + 5);
        exp_ev(1, 1, 0, 0, 2, s + 10);
        sym(B); sym(B); sym(C); sym(C); sym(C);
        sym(B); sym(B); sym(C); sym(C); sym(C);
        idle(1);
        chk("t2_cnt", match_cnt, 2);

        // BBCCCC gives one match only, then the window expires.
        go(2, 8, s);
        exp_ev(1, 0, 0, 1, 1, s + 5);
        exp_ev(0, 0, 1, 0, 1, s + 8);
        sym(B); sym(B); sym(C); sym(C); sym(C); sym(C);
        idle(3);
        chk("t2b_cnt", match_cnt, 1);

        // Timeout 10 cycles after start with one match.
        go(3, 10, s);
        exp_ev(1, 0, 0, 1, 1, s + 5);
        exp_ev(0, 0, 1, 0, 1, s + 10);
        sym(B); sym(B); sym(C); sym(C); sym(C);
        idle(6);

        // Completion and expiry on the same edge: done wins.
        go(1, 5, s);
        exp_ev(1, 1, 0, 0, 1, s + 5);
        sym(B); sym(B); sym(C); sym(C); sym(C);
        idle(2);

        // din_valid gaps between symbols.
        go(1, 40, s);
        exp_ev(1, 1, 0, 0, 1, s + 9);
        sym(B); idle(1); sym(B); idle(1); sym(C); idle(1); sym(C); idle(1); sym(C);
        idle(1);

        // BBBCCC, with a start (target 0) issued mid-run that must be ignored.
        go(1, 40, s);
        exp_ev(1, 1, 0, 0, 1, s + 7);
        sym(B); sym(B); sym(B);
        target = '0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sym(C); sym(C); sym(C);
        idle(1);

        // BBCBBCCC.
        go(1, 40, s);
        exp_ev(1, 1, 0, 0, 1, s + 8);
        sym(B); sym(B); sym(C); sym(B); sym(B); sym(C); sym(C); sym(C);
        idle(1);

        // Abort mid-run: no pulse.
        go(1, 40, s);
        sym(B); sym(B); sym(C); sym(C);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", match_cnt, 0);

        // Abort on the hit edge: hit counted, no done.
        go(1, 40, s);
        exp_ev(1, 0, 0, 0, 1, s + 5);
        sym(B); sym(B); sym(C); sym(C);
        step(1'b0, 1'b1, C, 1'b1);
        idle(1);
        chk("abort_hit_busy", busy, 0);
        chk("abort_hit_cnt", match_cnt, 1);

        // Abort in IDLE does nothing; match_cnt holds.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_cnt", match_cnt, 1);

        // target == 0: immediate done, count cleared.
        target = '0; window = WW'(5);
        exp_ev(0, 1, 0, 0, 0, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t0_busy", busy, 0);

        // window == 0: immediate timeout.
        target = CW'(3); window = '0;
        exp_ev(0, 0, 1, 0, 0, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("w0_busy", busy, 0);

        // Reset mid-run clears everything at once.
        go(2, 40, s);
        exp_ev(1, 0, 0, 1, 1, s + 5);
        sym(B); sym(B); sym(C); sym(C); sym(C);
        sym(B);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pattern", pattern, 0);
        chk("midrst_done", done, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_cnt", match_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        target = '0;
        exp_ev(0, 1, 0, 0, 0, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of the match target and match counter.
REQ-002 SHALL have parameter WIN_W, default 16, the width of the window length and cycle counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that arms a run; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminates a run with no done or timeout.
REQ-007 SHALL have port din, input, 1 bit: serial symbol, where B=0 and C=1.
REQ-008 SHALL have port din_valid, input, 1 bit: qualifies din.
REQ-009 SHALL have port target, input, CNT_W bits: number of matches required; latched on start.
REQ-010 SHALL have port window, input, WIN_W bits: run length in clk cycles; latched on start.
REQ-011 SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-012 SHALL have port pattern, output, 1 bit: registered one-cycle pulse per BBCCC match.
REQ-013 SHALL have port match_cnt, output, CNT_W bits: matches counted in the current or last run.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when target is reached.
REQ-015 SHALL have port timeout, output, 1 bit: one-cycle pulse when the window expires first.

Function
REQ-016 SHALL implement controller states IDLE and RUN.
REQ-017 In IDLE, on start with target!=0 and window!=0, SHALL at that edge: latch target and window, clear match_cnt and the cycle counter, force the detector to S_RESET, and enter RUN.
REQ-018 In IDLE, on start with target==0, SHALL pulse done on the next cycle with match_cnt=0 and remain in IDLE.
REQ-019 In IDLE, on start with target!=0 and window==0, SHALL pulse timeout on the next cycle and remain in IDLE.
REQ-020 SHALL ignore start while in RUN.
REQ-021 Detector (non-overlapping Mealy) SHALL use states S_RESET, S_B, S_BB, S_BBC, S_BBCC, and SHALL advance only in RUN on edges with din_valid=1.
REQ-022 When din_valid=0, the detector SHALL hold its state.
REQ-023 Detector transitions, input B:
- S_RESET -> S_B
- S_B -> S_BB
- S_BB -> S_BB
- S_BBC -> S_B
- S_BBCC -> S_RESET
REQ-024 Detector transitions, input C:
- S_RESET -> S_RESET
- S_B -> S_RESET
- S_BB -> S_BBC
- S_BBC -> S_BBCC
- S_BBCC -> S_RESET, with hit asserted
REQ-025 hit SHALL be combinational and valid in the cycle the final C is presented with din_valid=1.
REQ-026 On an edge with hit, SHALL increment match_cnt and set pattern=1 for the following cycle; match_cnt never exceeds target.
REQ-027 The cycle counter SHALL increment every RUN cycle, regardless of din_valid.
REQ-028 On the edge where hit occurs and match_cnt+1==target, SHALL go to IDLE and pulse done; done and pattern are coincident.
REQ-029 On the edge where the cycle counter equals window-1 and no completing hit occurs, SHALL go to IDLE and pulse timeout.
REQ-030 If completion and window expiry occur on the same edge, done SHALL win and timeout SHALL stay 0.
REQ-031 abort in RUN SHALL cause a return to IDLE at the next edge, with no done or timeout; abort SHALL override a same-edge completion or expiry.
REQ-032 A hit counted on the abort edge SHALL still update match_cnt and pattern.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 match_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-035 done and timeout SHALL never be high in the same cycle.

Reset
REQ-036 On rst=1, SHALL asynchronously set: state=IDLE, detector=S_RESET, busy=0, pattern=0, done=0, timeout=0, match_cnt=0, cycle counter=0, latched target=0, latched window=0.
REQ-037 Reset mid-run SHALL discard the run silently, with no done or timeout.
REQ-038 After rst deasserts, the first start SHALL be honoured on the first clk edge.

Structure
REQ-039 Detector state encodings (one-hot, 5 bits), controller state encodings, and the symbol constants B/C SHALL reside in a shared package seq_pkg.
REQ-040 The detector SHALL be a sub-module seq_bbccc_det with ports clk, rst, clr, en, din, hit.
REQ-041 The controller SHALL own the counters, the latched configuration, and the output registers.

Verification
REQ-042 target=1, window=20, stream B B C C C valid -> pattern and done high on the cycle after the 5th symbol; match_cnt=1; busy falls.
REQ-043 target=2, window=30, stream BBCCC BBCCC -> two pattern pulses, done with the second, match_cnt=2; stream BBCCCC -> exactly 1 match (non-overlap).
REQ-044 target=3, window=10, one BBCCC only -> timeout pulse 10 cycles after start, match_cnt=1, done never high.
REQ-045 target=1, window=5, BBCCC on cycles 0-4 -> done=1 and timeout=0 (tie).
REQ-046 din_valid toggled 0/1 between symbols of BBCCC -> match still detected; B B B C C C -> 1 match; B B C B B C C C -> 1 match.
REQ-047 abort in RUN -> IDLE with no pulse; rst asserted mid-run -> all outputs 0 immediately; start with target=0 -> done pulse next cycle.
